// File: rtl/laplacian_nbr_filter.sv
// 3x3 Laplacian edge/sharpen filter with 4/8-neighbour kernel, magnitude or sharpen output, 4-clock latency.
// Optional build macro LAP_THRESH_EN adds cfg_thresh and turns magnitude mode into a binary edge map.
module laplacian_nbr_filter #(
    parameter int DATA_WIDTH = 8,
    parameter int H_DISP     = 800,
    parameter int V_DISP     = 600
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_kernel,
    input  logic                  cfg_mode,
`ifdef LAP_THRESH_EN
    input  logic [DATA_WIDTH-1:0] cfg_thresh,
`endif
    input  logic                  pre_img_vsync,
    input  logic                  pre_img_hsync,
    input  logic                  pre_img_valid,
    input  logic [DATA_WIDTH-1:0] pre_img_data,
    output logic                  post_img_vsync,
    output logic                  post_img_hsync,
    output logic                  post_img_valid,
    output logic [DATA_WIDTH-1:0] post_img_data
);

    localparam int CW = $clog2(H_DISP + 1);
    localparam int AW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int RW = $clog2(V_DISP + 1);
    localparam int SW = DATA_WIDTH + 2;
    localparam int LW = DATA_WIDTH + 5;

    localparam logic [CW-1:0] H_LIM  = CW'(H_DISP);
    localparam logic [CW-1:0] COL2   = CW'(2);
    localparam logic [RW-1:0] ROW2   = RW'(2);
    localparam logic [LW-1:0] MAXV_L = {5'b0, {DATA_WIDTH{1'b1}}};

    logic [3:0] vld_sr;
    logic [3:0] hs_sr;
    logic [3:0] vs_sr;

    logic vs_rise;
    logic vld_fall;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          frame_ok;
    logic          kern_q;
    logic          mode_q;
`ifdef LAP_THRESH_EN
    logic [DATA_WIDTH-1:0] thr_q;
`endif

    logic [DATA_WIDTH-1:0] lb_a [H_DISP];
    logic [DATA_WIDTH-1:0] lb_b [H_DISP];
    logic [AW-1:0]         addr;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    logic [DATA_WIDTH-1:0] win [3][3];
    logic                  keep1;
    logic                  kern1;
    logic                  mode1;

    logic [SW-1:0]         sum4;
    logic [SW-1:0]         sumd;
    logic [DATA_WIDTH-1:0] ctr2;
    logic                  keep2;
    logic                  kern2;
    logic                  mode2;

    logic [LW-1:0]         lap_nxt;
    logic [LW-1:0]         lap3;
    logic [DATA_WIDTH-1:0] ctr3;
    logic                  keep3;
    logic                  mode3;

    logic [LW-1:0]         mag;
    logic [LW-1:0]         shp;
    logic [DATA_WIDTH-1:0] pix_nxt;

    // Sync delay line; tap 0 doubles as the previous-cycle sample for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_sr <= '0;
            hs_sr  <= '0;
            vs_sr  <= '0;
        end else begin
            vld_sr <= {vld_sr[2:0], pre_img_valid};
            hs_sr  <= {hs_sr[2:0], pre_img_hsync};
            vs_sr  <= {vs_sr[2:0], pre_img_vsync};
        end
    end

    assign post_img_valid = vld_sr[3];
    assign post_img_hsync = hs_sr[3];
    assign post_img_vsync = vs_sr[3];

    assign vs_rise  = pre_img_vsync & ~vs_sr[0];
    assign vld_fall = vld_sr[0] & ~pre_img_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else begin
            if (vld_fall) begin
                col <= '0;
            end else if (pre_img_valid && (col < H_LIM)) begin
                col <= col + 1'b1;
            end
            if (vs_rise) begin
                row <= '0;
            end else if (vld_fall && (row != '1)) begin
                row <= row + 1'b1;
            end
        end
    end

    // Configuration is frozen per frame; frame_ok also blocks output after a mid-frame reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_ok <= 1'b0;
            kern_q   <= 1'b0;
            mode_q   <= 1'b0;
`ifdef LAP_THRESH_EN
            thr_q    <= '0;
`endif
        end else if (vs_rise) begin
            frame_ok <= 1'b1;
            kern_q   <= cfg_kernel;
            mode_q   <= cfg_mode;
`ifdef LAP_THRESH_EN
            thr_q    <= cfg_thresh;
`endif
        end
    end

    assign in_range = (col < H_LIM);
    assign addr     = col[AW-1:0];
    assign rd_a     = in_range ? lb_a[addr] : '0;
    assign rd_b     = in_range ? lb_b[addr] : '0;

    // lb_a holds the previous line, lb_b the one before it.
    always_ff @(posedge clk) begin
        if (pre_img_valid && in_range) begin
            lb_a[addr] <= pre_img_data;
            lb_b[addr] <= rd_a;
        end
    end

    // Stage 1: window shift. Row 0 = line r-2, column 2 = newest pixel; centre is (r-1, c-1).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
            keep1 <= 1'b0;
            kern1 <= 1'b0;
            mode1 <= 1'b0;
        end else begin
            keep1 <= pre_img_valid & frame_ok & ~vs_rise & in_range
                     & (row >= ROW2) & (col >= COL2);
            kern1 <= kern_q;
            mode1 <= mode_q;
            if (pre_img_valid) begin
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= rd_b;
                win[1][2] <= rd_a;
                win[2][2] <= pre_img_data;
            end
        end
    end

    // Stage 2: orthogonal and diagonal neighbour sums.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum4  <= '0;
            sumd  <= '0;
            ctr2  <= '0;
            keep2 <= 1'b0;
            kern2 <= 1'b0;
            mode2 <= 1'b0;
        end else begin
            sum4  <= SW'(win[0][1]) + SW'(win[2][1]) + SW'(win[1][0]) + SW'(win[1][2]);
            sumd  <= SW'(win[0][0]) + SW'(win[0][2]) + SW'(win[2][0]) + SW'(win[2][2]);
            ctr2  <= win[1][1];
            keep2 <= keep1;
            kern2 <= kern1;
            mode2 <= mode1;
        end
    end

    // Stage 3: Laplacian in two's complement, LW bits cover +/- 8*MAXV.
    always_comb begin
        lap_nxt = {3'b0, ctr2, 2'b0} - {3'b0, sum4};
        if (kern2) begin
            lap_nxt = {2'b0, ctr2, 3'b0} - {3'b0, sum4} - {3'b0, sumd};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lap3  <= '0;
            ctr3  <= '0;
            keep3 <= 1'b0;
            mode3 <= 1'b0;
        end else begin
            lap3  <= lap_nxt;
            ctr3  <= ctr2;
            keep3 <= keep2;
            mode3 <= mode2;
        end
    end

    // Stage 4: magnitude or sharpen, clamped to the pixel range.
    always_comb begin
        mag     = lap3[LW-1] ? (LW'(0) - lap3) : lap3;
        shp     = {5'b0, ctr3} + lap3;
        pix_nxt = '0;
        if (!mode3) begin
`ifdef LAP_THRESH_EN
            pix_nxt = (mag >= {5'b0, thr_q}) ? '1 : '0;
`else
            pix_nxt = (mag > MAXV_L) ? '1 : mag[DATA_WIDTH-1:0];
`endif
        end else if (shp[LW-1]) begin
            pix_nxt = '0;
        end else if (shp > MAXV_L) begin
            pix_nxt = '1;
        end else begin
            pix_nxt = shp[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            post_img_data <= '0;
        end else begin
            post_img_data <= keep3 ? pix_nxt : '0;
        end
    end

endmodule

// File: tb/tb_laplacian_nbr_filter.sv
// Directed scoreboard bench for laplacian_nbr_filter (16-pixel lines, 8-bit pixels).
module tb_laplacian_nbr_filter;

    localparam int DW = 8;
    localparam int H  = 16;
    localparam int V  = 8;
    localparam int MAXC = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_kernel = 1'b0;
    logic          cfg_mode = 1'b0;
`ifdef LAP_THRESH_EN
    logic [DW-1:0] cfg_thresh = '0;
`endif
    logic          pre_vs = 1'b0;
    logic          pre_hs = 1'b0;
    logic          pre_v = 1'b0;
    logic [DW-1:0] pre_d = '0;
    logic          post_vs;
    logic          post_hs;
    logic          post_v;
    logic [DW-1:0] post_d;

    laplacian_nbr_filter #(.DATA_WIDTH(DW), .H_DISP(H), .V_DISP(V)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_kernel(cfg_kernel),
        .cfg_mode(cfg_mode),
`ifdef LAP_THRESH_EN
        .cfg_thresh(cfg_thresh),
`endif
        .pre_img_vsync(pre_vs),
        .pre_img_hsync(pre_hs),
        .pre_img_valid(pre_v),
        .pre_img_data(pre_d),
        .post_img_vsync(post_vs),
        .post_img_hsync(post_hs),
        .post_img_valid(post_v),
        .post_img_data(post_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          r;
        int          c;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t          sbq[$];
    int            n_assert = 0;
    int            n_fail = 0;
    int            img [0:V-1][0:MAXC-1];
    logic [DW-1:0] out_img [0:V-1][0:MAXC-1];
    bit            fok_m = 1'b0;
    bit            k_m = 1'b0;
    bit            m_m = 1'b0;
    int            th_m = 0;
    logic [2:0]    hist [4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference sync history, cleared by reset like the DUT delay line.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist[i] <= 3'b0;
        end else begin
            hist[0] <= {pre_vs, pre_hs, pre_v};
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        n_assert++;
        assert ({post_vs, post_hs, post_v} === hist[3])
        else begin
            n_fail++;
            $error("FAIL sync_delay observed=%b expected=%b", {post_vs, post_hs, post_v}, hist[3]);
        end
        if (post_v === 1'b1) begin
            n_assert++;
            assert (sbq.size() > 0)
            else begin
                n_fail++;
                $error("FAIL sb_underflow observed=%0d expected=>0", sbq.size());
            end
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                out_img[e.r][e.c] = post_d;
                n_assert++;
                assert (post_d === e.exp)
                else begin
                    n_fail++;
                    $error("FAIL pix(%0d,%0d) observed=%0d expected=%0d", e.r, e.c, post_d, e.exp);
                end
            end
        end else begin
            n_assert++;
            assert (post_d === '0)
            else begin
                n_fail++;
                $error("FAIL idle_data observed=%0d expected=0", post_d);
            end
        end
    end

    function automatic logic [DW-1:0] expv(input int r, input int c);
        int cc, s4, sd, lap, mag, sum;
        if (!fok_m || r < 2 || c < 2 || c >= H) return '0;
        cc  = img[r-1][c-1];
        s4  = img[r-2][c-1] + img[r][c-1] + img[r-1][c-2] + img[r-1][c];
        sd  = img[r-2][c-2] + img[r-2][c] + img[r][c-2] + img[r][c];
        lap = k_m ? (8 * cc - s4 - sd) : (4 * cc - s4);
        if (!m_m) begin
            mag = (lap < 0) ? -lap : lap;
`ifdef LAP_THRESH_EN
            return (mag >= th_m) ? 8'd255 : 8'd0;
`else
            return (mag > 255) ? 8'd255 : DW'(mag);
`endif
        end
        sum = cc + lap;
        if (sum < 0) return '0;
        if (sum > 255) return 8'd255;
        return DW'(sum);
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit hs, input bit vs, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        pre_v  = v;
        pre_hs = hs;
        pre_vs = vs;
        pre_d  = d;
    endtask

    task automatic fill(input int bg, input int imp);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < MAXC; c++) img[r][c] = bg;
        img[5][5] = imp;
    endtask

    task automatic run_frame(input int cols, input int tog_row, input int rst_row);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < MAXC; c++) out_img[r][c] = 8'hA5;
        drive(1'b0, 1'b0, 1'b1, '0);
        k_m   = cfg_kernel;
        m_m   = cfg_mode;
`ifdef LAP_THRESH_EN
        th_m  = int'(cfg_thresh);
`endif
        fok_m = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, '0);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (r == tog_row && c == 0) cfg_kernel = ~cfg_kernel;
                drive(1'b1, 1'b1, 1'b0, DW'(img[r][c]));
                sbq.push_back('{r: r, c: c, exp: expv(r, c)});
                if (r == rst_row && c == cols / 2) begin
                    @(posedge clk);
                    #1;
                    rst_n = 1'b0;
                    pre_v = 1'b0;
                    pre_hs = 1'b0;
                    pre_d = '0;
                    @(posedge clk);
                    #1;
                    chk("rst_mid_valid", {7'b0, post_v}, '0);
                    chk("rst_mid_data", post_d, '0);
                    @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    sbq.delete();
                    fok_m = 1'b0;
                end
            end
            repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
        end
        repeat (8) drive(1'b0, 1'b0, 1'b0, '0);
        n_assert++;
        assert (sbq.size() == 0)
        else begin
            n_fail++;
            $error("FAIL pixel_count observed=%0d pending expected=0", sbq.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {7'b0, post_v}, '0);
        chk("rst_vsync", {7'b0, post_vs}, '0);
        chk("rst_hsync", {7'b0, post_hs}, '0);
        chk("rst_data", post_d, '0);
        rst_n = 1'b1;

        fill(100, 100);
        cfg_kernel = 1'b0;
        cfg_mode   = 1'b0;
        run_frame(H, -1, -1);
        chk("flat_m0_int", out_img[4][4], 8'd0);
        chk("flat_m0_last", out_img[7][15], 8'd0);

        cfg_mode = 1'b1;
        run_frame(H, -1, -1);
        chk("flat_m1_int", out_img[4][4], 8'd100);
        chk("flat_m1_last", out_img[7][15], 8'd100);
        chk("flat_m1_row0", out_img[0][8], 8'd0);
        chk("flat_m1_row1", out_img[1][8], 8'd0);
        chk("flat_m1_col0", out_img[4][0], 8'd0);
        chk("flat_m1_col1", out_img[4][1], 8'd0);

        fill(0, 20);
        cfg_mode = 1'b0;
        run_frame(H, -1, -1);
        chk("imp4_centre", out_img[6][6], 8'd80);
        chk("imp4_n", out_img[5][6], 8'd20);
        chk("imp4_s", out_img[7][6], 8'd20);
        chk("imp4_w", out_img[6][5], 8'd20);
        chk("imp4_e", out_img[6][7], 8'd20);
        chk("imp4_diag_nw", out_img[5][5], 8'd0);
        chk("imp4_diag_se", out_img[7][7], 8'd0);

        cfg_kernel = 1'b1;
        run_frame(H, -1, -1);
        chk("imp8_centre", out_img[6][6], 8'd160);
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) chk("imp8_ring", out_img[6+dr][6+dc], 8'd20);

        fill(50, 60);
        cfg_kernel = 1'b0;
        cfg_mode   = 1'b1;
        run_frame(H, -1, -1);
        chk("shp_centre", out_img[6][6], 8'd100);
        chk("shp_n", out_img[5][6], 8'd40);
        chk("shp_s", out_img[7][6], 8'd40);
        chk("shp_w", out_img[6][5], 8'd40);
        chk("shp_e", out_img[6][7], 8'd40);

        fill(0, 255);
        run_frame(H, -1, -1);
        chk("shp255_centre", out_img[6][6], 8'd255);
        chk("shp255_n", out_img[5][6], 8'd0);
        chk("shp255_e", out_img[6][7], 8'd0);

        fill(100, 100);
        run_frame(H + 3, -1, -1);
        chk("long_last_in", out_img[4][15], 8'd100);
        chk("long_over0", out_img[4][16], 8'd0);
        chk("long_over1", out_img[4][17], 8'd0);
        chk("long_over2", out_img[4][18], 8'd0);

        fill(0, 20);
        cfg_kernel = 1'b0;
        cfg_mode   = 1'b0;
        run_frame(H, 2, -1);
        chk("tog_same_frame", out_img[6][6], 8'd80);
        chk("tog_same_diag", out_img[5][5], 8'd0);
        run_frame(H, -1, -1);
        chk("tog_next_frame", out_img[6][6], 8'd160);
        chk("tog_next_diag", out_img[5][5], 8'd20);

        cfg_kernel = 1'b0;
        run_frame(H, -1, 3);
        chk("rst_frame_centre", out_img[6][6], 8'd0);
        chk("rst_frame_n", out_img[5][6], 8'd0);
        run_frame(H, -1, -1);
        chk("post_rst_centre", out_img[6][6], 8'd80);

`ifdef LAP_THRESH_EN
        cfg_thresh = 8'd50;
        cfg_kernel = 1'b1;
        run_frame(H, -1, -1);
        chk("thr_centre", out_img[6][6], 8'd255);
        chk("thr_nw", out_img[5][5], 8'd0);
        chk("thr_n", out_img[5][6], 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
